// File: rtl/fmps_readout_arbiter.sv
// fmps_readout_arbiter: shares the single FMPS readout RAM read port between a
// bitmap-driven stream walker (priority) and single-word host reads. A starve
// counter bounds how many walker grants a waiting host read can be passed over.
// Every grant travels a two-stage tag pipeline that lines up with the RAM's
// one-cycle read latency. Outputs are registered two edges after the grant.
module fmps_readout_arbiter #(
    parameter int INDEX_WIDTH      = 5,
    parameter int HOST_SLOT_PERIOD = 4
) (
    input  logic                        sysClk_i,
    input  logic                        sysReset_i,
    input  logic                        start_i,
    input  logic [(1<<INDEX_WIDTH)-1:0] bitmap_i,
    output logic                        busy_o,
    output logic                        overrun_o,
    output logic [INDEX_WIDTH-1:0]      ramAddress_o,
    input  logic [31:0]                 ramData_i,
    output logic [INDEX_WIDTH-1:0]      streamIndex_o,
    output logic [31:0]                 streamData_o,
    output logic                        streamValid_o,
    output logic                        streamLast_o,
    input  logic                        hostStrobe_i,
    input  logic [INDEX_WIDTH-1:0]      hostAddress_i,
    output logic                        hostAck_o,
    output logic [31:0]                 hostData_o
);

    localparam int         NUM_ENTRIES = 1 << INDEX_WIDTH;
    localparam int         STAGES      = 2;
    localparam logic [3:0] SLOT_LIMIT  = 4'(HOST_SLOT_PERIOD);

    typedef enum logic {
        ST_IDLE,
        ST_WALK
    } state_t;

    // Tag carried alongside each RAM read until its data is registered out.
    typedef struct packed {
        logic                   host;
        logic [INDEX_WIDTH-1:0] idx;
        logic                   last;
    } tag_t;

    // Walker state
    state_t                 state_q, state_d;
    logic [NUM_ENTRIES-1:0] mask_q, mask_d;
    logic                   overrun_q, overrun_d;
    logic                   start_accept;

    // Host request state
    logic                   host_pend_q, host_pend_d;
    logic [INDEX_WIDTH-1:0] host_addr_q, host_addr_d;
    logic [3:0]             starve_q, starve_d;
    logic                   host_in_flight;
    logic                   host_accept;

    // Arbitration
    logic                   mask_empty;
    logic                   host_gnt;
    logic                   walk_gnt;
    logic [INDEX_WIDTH-1:0] walk_idx;
    logic [NUM_ENTRIES-1:0] mask_clr;
    logic                   walk_last;

    // Read pipeline and registered outputs
    logic [INDEX_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [STAGES:1]        vld_pipe_q;
    tag_t                   tag1_q, tag1_d;
    tag_t                   tag2_q;
    logic [INDEX_WIDTH-1:0] stream_idx_q;
    logic [31:0]            stream_data_q;
    logic                   stream_valid_q;
    logic                   stream_last_q;
    logic                   host_ack_q;
    logic [31:0]            host_data_q;

    // Pick the grant: host when its slot is due or the walker has nothing left,
    // else the lowest remaining bitmap entry (cleared via x & (x-1)).
    always_comb begin
        mask_empty = (mask_q == '0);
        host_gnt   = host_pend_q && (mask_empty || (starve_q == SLOT_LIMIT));
        walk_gnt   = !host_gnt && !mask_empty;
        mask_clr   = mask_q & (mask_q - NUM_ENTRIES'(1));
        walk_last  = walk_gnt && (mask_clr == '0);
        walk_idx   = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (mask_q[i]) walk_idx = INDEX_WIDTH'(i);
        end
    end

    // Walker FSM next state: accept start only when idle, drop busy once the
    // final word of the walk has been presented.
    always_comb begin
        state_d      = state_q;
        mask_d       = mask_q;
        overrun_d    = 1'b0;
        start_accept = start_i && (state_q == ST_IDLE);
        case (state_q)
            ST_IDLE: begin
                if (start_accept) begin
                    mask_d = bitmap_i;
                    if (bitmap_i != '0) state_d = ST_WALK;
                end
            end
            ST_WALK: begin
                overrun_d = start_i;
                if (walk_gnt) mask_d = mask_clr;
                if (stream_valid_q && stream_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Walker state register
    always_ff @(posedge sysClk_i or posedge sysReset_i) begin
        if (sysReset_i) begin
            state_q   <= ST_IDLE;
            mask_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            overrun_q <= overrun_d;
        end
    end

    // Host request bookkeeping: one outstanding read at a time, starve count
    // advances only while a host read is being passed over.
    always_comb begin
        host_in_flight = (vld_pipe_q[1] && tag1_q.host) || (vld_pipe_q[2] && tag2_q.host);
        host_accept    = hostStrobe_i && !host_pend_q && !host_in_flight;
        host_pend_d    = host_pend_q;
        host_addr_d    = host_addr_q;
        starve_d       = starve_q;
        if (host_gnt) host_pend_d = 1'b0;
        if (host_accept) begin
            host_pend_d = 1'b1;
            host_addr_d = hostAddress_i;
        end
        if (host_gnt)
            starve_d = 4'd0;
        else if (walk_gnt && host_pend_q)
            starve_d = starve_q + 4'd1;
    end

    // Host request registers
    always_ff @(posedge sysClk_i or posedge sysReset_i) begin
        if (sysReset_i) begin
            host_pend_q <= 1'b0;
            host_addr_q <= '0;
            starve_q    <= 4'd0;
        end else begin
            host_pend_q <= host_pend_d;
            host_addr_q <= host_addr_d;
            starve_q    <= starve_d;
        end
    end

    // Stage-1 load: RAM address and tag for whichever source won this cycle.
    always_comb begin
        ram_addr_d = ram_addr_q;
        tag1_d     = tag1_q;
        if (host_gnt) begin
            ram_addr_d = host_addr_q;
            tag1_d     = '{host: 1'b1, idx: host_addr_q, last: 1'b0};
        end else if (walk_gnt) begin
            ram_addr_d = walk_idx;
            tag1_d     = '{host: 1'b0, idx: walk_idx, last: walk_last};
        end
    end

    // Read pipeline: tag follows the RAM latency, stage 2 registers ramData
    // into the stream or host outputs; unqualified data holds its last value.
    always_ff @(posedge sysClk_i or posedge sysReset_i) begin
        if (sysReset_i) begin
            ram_addr_q     <= '0;
            vld_pipe_q     <= '0;
            tag1_q         <= '0;
            tag2_q         <= '0;
            stream_idx_q   <= '0;
            stream_data_q  <= '0;
            stream_valid_q <= 1'b0;
            stream_last_q  <= 1'b0;
            host_ack_q     <= 1'b0;
            host_data_q    <= '0;
        end else begin
            ram_addr_q    <= ram_addr_d;
            tag1_q        <= tag1_d;
            vld_pipe_q[1] <= host_gnt || walk_gnt;
            vld_pipe_q[2] <= vld_pipe_q[1];
            tag2_q        <= tag1_q;
            if (vld_pipe_q[2] && !tag2_q.host) begin
                stream_idx_q   <= tag2_q.idx;
                stream_data_q  <= ramData_i;
                stream_valid_q <= 1'b1;
                stream_last_q  <= tag2_q.last;
            end else begin
                stream_valid_q <= 1'b0;
                stream_last_q  <= 1'b0;
            end
            host_ack_q <= vld_pipe_q[2] && tag2_q.host;
            if (vld_pipe_q[2] && tag2_q.host) host_data_q <= ramData_i;
        end
    end

    assign busy_o        = (state_q == ST_WALK);
    assign overrun_o     = overrun_q;
    assign ramAddress_o  = ram_addr_q;
    assign streamIndex_o = stream_idx_q;
    assign streamData_o  = stream_data_q;
    assign streamValid_o = stream_valid_q;
    assign streamLast_o  = stream_last_q;
    assign hostAck_o     = host_ack_q;
    assign hostData_o    = host_data_q;

endmodule

// File: tb/tb_fmps_readout_arbiter.sv
// Directed bench for fmps_readout_arbiter: walks, host slots, overrun and reset.
module tb_fmps_readout_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] bitmap = '0;
    logic        busy, overrun;
    logic [4:0]  ram_addr;
    logic [31:0] ram_data = '0;
    logic [4:0]  sidx;
    logic [31:0] sdata;
    logic        svalid, slast;
    logic        hstrobe = 1'b0;
    logic [4:0]  haddr = '0;
    logic        hack;
    logic [31:0] hdata;

    int n_vec = 0;
    int n_err = 0;

    fmps_readout_arbiter #(.INDEX_WIDTH(5), .HOST_SLOT_PERIOD(4)) dut (
        .sysClk_i      (clk),
        .sysReset_i    (rst),
        .start_i       (start),
        .bitmap_i      (bitmap),
        .busy_o        (busy),
        .overrun_o     (overrun),
        .ramAddress_o  (ram_addr),
        .ramData_i     (ram_data),
        .streamIndex_o (sidx),
        .streamData_o  (sdata),
        .streamValid_o (svalid),
        .streamLast_o  (slast),
        .hostStrobe_i  (hstrobe),
        .hostAddress_i (haddr),
        .hostAck_o     (hack),
        .hostData_o    (hdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ram_word(input logic [4:0] a);
        return 32'hC0DE_0000 ^ {27'd0, a} ^ {19'd0, a, 8'd0};
    endfunction

    // Synchronous-read RAM model: data valid one edge after the address.
    always @(posedge clk) ram_data <= ram_word(ram_addr);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_ovr"}, 32'(overrun), 0);
        chk({tag, "_raddr"}, 32'(ram_addr), 0);
        chk({tag, "_sidx"}, 32'(sidx), 0);
        chk({tag, "_sdata"}, sdata, 0);
        chk({tag, "_svalid"}, 32'(svalid), 0);
        chk({tag, "_slast"}, 32'(slast), 0);
        chk({tag, "_hack"}, 32'(hack), 0);
        chk({tag, "_hdata"}, hdata, 0);
    endtask

    // Start a walk of bm with no host traffic; optionally re-assert start after
    // cycle rej_a / rej_b to provoke overrun pulses.
    task automatic expect_walk(input logic [31:0] bm, input int rej_a, input int rej_b);
        int idxq[$];
        int n;
        bit rej_prev;
        for (int i = 0; i < 32; i++) if (bm[i]) idxq.push_back(i);
        n = idxq.size();
        start  = 1'b1;
        bitmap = bm;
        step();
        start  = 1'b0;
        chk("walk_busy_s", 32'(busy), (n != 0) ? 1 : 0);
        chk("walk_ovr_s", 32'(overrun), 0);
        rej_prev = 1'b0;
        for (int k = 1; k <= n + 3; k++) begin
            step();
            start = 1'b0;
            chk("walk_valid", 32'(svalid), (k >= 3 && k <= n + 2) ? 1 : 0);
            chk("walk_last", 32'(slast), (n != 0 && k == n + 2) ? 1 : 0);
            chk("walk_busy", 32'(busy), (n != 0 && k <= n + 2) ? 1 : 0);
            chk("walk_ovr", 32'(overrun), rej_prev ? 1 : 0);
            if (k >= 3 && k <= n + 2) begin
                chk("walk_idx", 32'(sidx), 32'(idxq[k-3]));
                chk("walk_data", sdata, ram_word(5'(idxq[k-3])));
            end
            rej_prev = (k == rej_a || k == rej_b);
            if (rej_prev) begin
                start  = 1'b1;
                bitmap = 32'hFFFF_FFFF;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst = 1'b0;
        step();
        chk("idle_busy", 32'(busy), 0);

        // Sparse walk 0, 5, 31
        expect_walk(32'h8000_0021, -1, -1);

        // Empty bitmap: nothing happens
        expect_walk(32'h0000_0000, -1, -1);

        // Full walk with a host read on the start edge: host slot after 4 grants
        start   = 1'b1;
        bitmap  = 32'hFFFF_FFFF;
        hstrobe = 1'b1;
        haddr   = 5'd7;
        step();
        start   = 1'b0;
        hstrobe = 1'b0;
        haddr   = 5'd0;
        chk("full_busy_s", 32'(busy), 1);
        for (int k = 1; k <= 36; k++) begin
            bit ev;
            int ei;
            step();
            ev = (k >= 3 && k <= 6) || (k >= 8 && k <= 35);
            ei = (k <= 6) ? k - 3 : k - 4;
            chk("full_valid", 32'(svalid), ev ? 1 : 0);
            chk("full_last", 32'(slast), (k == 35) ? 1 : 0);
            chk("full_hack", 32'(hack), (k == 7) ? 1 : 0);
            chk("full_busy", 32'(busy), (k <= 35) ? 1 : 0);
            if (ev) begin
                chk("full_idx", 32'(sidx), 32'(ei));
                chk("full_data", sdata, ram_word(5'(ei)));
            end
            if (k == 7) chk("full_hdata", hdata, ram_word(5'd7));
        end
        chk("full_hdata_hold", hdata, ram_word(5'd7));
        chk("full_sidx_hold", 32'(sidx), 31);

        // Overrun mid-walk and during the streamLast cycle, then a fresh start
        expect_walk(32'h0000_0006, 1, 4);
        expect_walk(32'h0000_0001, -1, -1);

        // Host: second strobe while pending, third while in flight, both ignored
        hstrobe = 1'b1;
        haddr   = 5'd3;
        step();
        haddr = 5'd9;
        chk("h1_ack0", 32'(hack), 0);
        step();
        haddr = 5'd10;
        chk("h1_ack1", 32'(hack), 0);
        step();
        hstrobe = 1'b0;
        chk("h1_ack2", 32'(hack), 0);
        step();
        chk("h1_ack3", 32'(hack), 1);
        chk("h1_data", hdata, ram_word(5'd3));
        for (int k = 0; k < 3; k++) begin
            step();
            chk("h1_noack", 32'(hack), 0);
        end
        chk("h1_hold", hdata, ram_word(5'd3));
        hstrobe = 1'b1;
        haddr   = 5'd12;
        step();
        hstrobe = 1'b0;
        step();
        chk("h2_ack1", 32'(hack), 0);
        step();
        chk("h2_ack2", 32'(hack), 0);
        step();
        chk("h2_ack3", 32'(hack), 1);
        chk("h2_data", hdata, ram_word(5'd12));

        // Asynchronous reset mid-walk
        start  = 1'b1;
        bitmap = 32'hFFFF_FFFF;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("mr_valid_pre", 32'(svalid), 1);
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mr");
        #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("mr_busy", 32'(busy), 0);
            chk("mr_valid", 32'(svalid), 0);
            chk("mr_hack", 32'(hack), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
